// File: rtl/data_path_p.sv
// Parametrised data path: program counter, NREG x DW register file, ALU with Z/C
// flags, and an IDLE -> READ -> EXEC -> WB sequencer launched by en_in.
module data_path_p_alu #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    func,
  output logic [DW-1:0] res,
  output logic          c
);
  logic [DW:0] wide;

  always_comb begin
    wide = '0;
    res  = '0;
    c    = 1'b0;
    case (func)
      3'b000: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[DW-1:0];
        c    = wide[DW];
      end
      // borrow shows up as bit DW of the widened difference
      3'b001: begin
        wide = {1'b0, a} - {1'b0, b};
        res  = wide[DW-1:0];
        c    = wide[DW];
      end
      3'b010: res = a & b;
      3'b011: res = a | b;
      3'b100: res = a ^ b;
      3'b101: begin
        res = {a[DW-2:0], 1'b0};
        c   = a[DW-1];
      end
      3'b110: begin
        res = {1'b0, a[DW-1:1]};
        c   = a[0];
      end
      default: res = b;
    endcase
  end
endmodule

module data_path_p #(
  parameter int DW   = 16,
  parameter int NREG = 4,
  parameter int RAW  = 2,
  parameter int PCW  = 16,
  parameter int OFFW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_pc_pulse,
  input  logic [1:0]      pc_ctrl,
  input  logic [OFFW-1:0] offset_addr,
  input  logic            en_in,
  input  logic [RAW-1:0]  rd,
  input  logic [RAW-1:0]  rs,
  input  logic            reg_wr,
  input  logic            alu_in_sel,
  input  logic [OFFW-1:0] offset,
  input  logic [2:0]      alu_func,
  output logic [PCW-1:0]  pc_out,
  output logic [DW-1:0]   alu_out,
  output logic            flag_z,
  output logic            flag_c,
  output logic            busy,
  output logic            en_out
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  typedef struct packed {
    logic [RAW-1:0]  rd;
    logic [RAW-1:0]  rs;
    logic            reg_wr;
    logic            alu_in_sel;
    logic [OFFW-1:0] offset;
    logic [2:0]      alu_func;
  } req_t;

  state_t                  state, state_nxt;
  req_t                    req;
  logic [NREG-1:0][DW-1:0] regs;
  logic [DW-1:0]           op_a, op_b, alu_res;
  logic                    alu_c;

  data_path_p_alu #(.DW(DW)) u_alu (
    .a    (op_a),
    .b    (op_b),
    .func (req.alu_func),
    .res  (alu_res),
    .c    (alu_c)
  );

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_in) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req     <= '0;
      regs    <= '0;
      op_a    <= '0;
      op_b    <= '0;
      alu_out <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      en_out  <= 1'b0;
    end else begin
      state  <= state_nxt;
      // registered so the pulse lands in the cycle the sequencer is back in IDLE
      en_out <= (state == WB);
      if (state == IDLE && en_in)
        req <= '{rd: rd, rs: rs, reg_wr: reg_wr, alu_in_sel: alu_in_sel,
                 offset: offset, alu_func: alu_func};
      if (state == READ) begin
        op_a <= regs[req.rd];
        op_b <= req.alu_in_sel ? DW'(req.offset) : regs[req.rs];
      end
      if (state == EXEC) begin
        alu_out <= alu_res;
        flag_z  <= (alu_res == '0);
        flag_c  <= alu_c;
      end
      if (state == WB && req.reg_wr)
        regs[req.rd] <= alu_out;
    end
  end

  // Branch reads flag_z as registered, so an EXEC on the same edge is not seen.
  always_ff @(posedge clk) begin
    if (rst)
      pc_out <= '0;
    else if (en_pc_pulse) begin
      case (pc_ctrl)
        2'b01:   pc_out <= pc_out + PCW'(1);
        2'b10:   pc_out <= PCW'(offset_addr);
        2'b11:   pc_out <= flag_z ? pc_out + PCW'($signed(offset_addr)) : pc_out + PCW'(1);
        default: pc_out <= pc_out;
      endcase
    end
  end
endmodule

// File: tb/tb_data_path_p.sv
// Randomised + directed bench for data_path_p against a transaction-level model.
module tb_data_path_p;
  localparam int DW = 16, NREG = 4, RAW = 2, PCW = 16, OFFW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            en_pc_pulse, en_in, reg_wr, alu_in_sel;
  logic [1:0]      pc_ctrl;
  logic [OFFW-1:0] offset_addr, offset;
  logic [RAW-1:0]  rd, rs;
  logic [2:0]      alu_func;
  logic [PCW-1:0]  pc_out;
  logic [DW-1:0]   alu_out;
  logic            flag_z, flag_c, busy, en_out;

  logic        en_pc_pulse2, en_in2, reg_wr2, alu_in_sel2;
  logic [1:0]  pc_ctrl2;
  logic [7:0]  offset_addr2, offset2;
  logic [2:0]  rd2, rs2, alu_func2;
  logic [15:0] pc_out2;
  logic [31:0] alu_out2;
  logic        flag_z2, flag_c2, busy2, en_out2;

  data_path_p #(.DW(DW), .NREG(NREG), .RAW(RAW), .PCW(PCW), .OFFW(OFFW)) dut (
    .clk(clk), .rst(rst), .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl),
    .offset_addr(offset_addr), .en_in(en_in), .rd(rd), .rs(rs), .reg_wr(reg_wr),
    .alu_in_sel(alu_in_sel), .offset(offset), .alu_func(alu_func), .pc_out(pc_out),
    .alu_out(alu_out), .flag_z(flag_z), .flag_c(flag_c), .busy(busy), .en_out(en_out));

  data_path_p #(.DW(32), .NREG(8), .RAW(3), .PCW(16), .OFFW(8)) dut2 (
    .clk(clk), .rst(rst), .en_pc_pulse(en_pc_pulse2), .pc_ctrl(pc_ctrl2),
    .offset_addr(offset_addr2), .en_in(en_in2), .rd(rd2), .rs(rs2), .reg_wr(reg_wr2),
    .alu_in_sel(alu_in_sel2), .offset(offset2), .alu_func(alu_func2), .pc_out(pc_out2),
    .alu_out(alu_out2), .flag_z(flag_z2), .flag_c(flag_c2), .busy(busy2), .en_out(en_out2));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted op's result is known at acceptance; it
  // becomes visible two edges later and is written back one edge after that.
  logic [63:0]    m_regs[NREG];
  logic [63:0]    m_alu, op_res;
  logic [PCW-1:0] m_pc;
  logic           m_z, m_c, m_busy, m_en_out, op_z, op_c, op_wr;
  bit             op_v = 0, chk_on = 0;
  int             op_t0, op_rd, edge_n = 0;

  function automatic void alu_m(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic c);
    logic [63:0] mask, s;
    mask = (64'd1 << DW) - 64'd1;
    c = 1'b0;
    case (f)
      3'd0: begin s = a + b; r = s & mask; c = s[DW]; end
      3'd1: begin r = (a - b) & mask; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = (a << 1) & mask; c = a[DW-1]; end
      3'd6: begin r = a >> 1; c = a[0]; end
      default: r = b;
    endcase
  endfunction

  task automatic model_step();
    bit was_busy;
    logic [63:0] a, b, r;
    logic c;
    int d;
    edge_n++;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_alu = 0; m_pc = 0; m_z = 0; m_c = 0; m_en_out = 0; op_v = 0;
    end else begin
      was_busy = op_v;
      if (en_pc_pulse) begin
        d = offset_addr[OFFW-1] ? int'(offset_addr) - (1 << OFFW) : int'(offset_addr);
        case (pc_ctrl)
          2'd1: m_pc = m_pc + 1'b1;
          2'd2: m_pc = PCW'(offset_addr);
          2'd3: m_pc = m_z ? PCW'(int'(m_pc) + d) : m_pc + 1'b1;
          default: ;
        endcase
      end
      m_en_out = 0;
      if (op_v && edge_n == op_t0 + 2) begin m_alu = op_res; m_z = op_z; m_c = op_c; end
      if (op_v && edge_n == op_t0 + 3) begin
        if (op_wr) m_regs[op_rd] = op_res;
        m_en_out = 1; op_v = 0;
      end
      if (!was_busy && en_in) begin
        a = m_regs[rd];
        b = alu_in_sel ? 64'(offset) : m_regs[rs];
        alu_m(alu_func, a, b, r, c);
        op_res = r; op_z = (r == 0); op_c = c; op_wr = reg_wr; op_rd = int'(rd);
        op_t0 = edge_n; op_v = 1;
      end
    end
    m_busy = op_v;
  endtask

  always @(negedge clk) if (chk_on) begin
    check("pc_out", 64'(pc_out), 64'(m_pc));
    check("alu_out", 64'(alu_out), m_alu);
    check("flag_z", 64'(flag_z), 64'(m_z));
    check("flag_c", 64'(flag_c), 64'(m_c));
    check("busy", 64'(busy), 64'(m_busy));
    check("en_out", 64'(en_out), 64'(m_en_out));
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic pc_op(input int ctrl, input int addr);
    en_pc_pulse = 1; pc_ctrl = ctrl[1:0]; offset_addr = addr[7:0];
    tick();
    en_pc_pulse = 0;
  endtask

  task automatic set_op(input int d, input int s, input bit wr, input bit sel, input int off, input int fn);
    rd = d[RAW-1:0]; rs = s[RAW-1:0]; reg_wr = wr; alu_in_sel = sel;
    offset = off[7:0]; alu_func = fn[2:0];
  endtask

  task automatic op1(input int d, input int s, input bit wr, input bit sel, input int off,
                     input int fn, output int lat, output int bcnt);
    set_op(d, s, wr, sel, off, fn);
    en_in = 1;
    tick();
    en_in = 0;
    lat = 0;
    bcnt = int'(busy);
    while (en_out !== 1'b1 && lat < 10) begin
      tick();
      lat++;
      if (busy === 1'b1) bcnt++;
    end
    check("op_done", 64'(en_out), 64'd1);
  endtask

  task automatic op2(input int d, input int s, input bit wr, input bit sel, input int off, input int fn);
    int n;
    rd2 = d[2:0]; rs2 = s[2:0]; reg_wr2 = wr; alu_in_sel2 = sel;
    offset2 = off[7:0]; alu_func2 = fn[2:0]; en_in2 = 1;
    tick();
    en_in2 = 0;
    n = 0;
    while (en_out2 !== 1'b1 && n < 10) begin tick(); n++; end
    check("op2_done", 64'(en_out2), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, bc, cnt;
    en_pc_pulse = 0; pc_ctrl = 0; offset_addr = 0; en_in = 0;
    set_op(0, 0, 0, 0, 0, 0);
    en_pc_pulse2 = 0; pc_ctrl2 = 0; offset_addr2 = 0; en_in2 = 0;
    rd2 = 0; rs2 = 0; reg_wr2 = 0; alu_in_sel2 = 0; offset2 = 0; alu_func2 = 0;
    rst = 1;
    tick();
    chk_on = 1;
    tick();
    rst = 0;
    check("rst_pc", 64'(pc_out), 64'd0);
    check("rst_alu", 64'(alu_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    repeat (3) pc_op(1, 0);
    check("pc_inc3", 64'(pc_out), 64'd3);
    pc_op(2, 'hF0);
    check("pc_load", 64'(pc_out), 64'h00F0);

    op1(1, 0, 1, 1, 5, 7, lat, bc);
    check("latency", 64'(lat), 64'd3);
    check("busy_cycles", 64'(bc), 64'd3);
    check("pass_imm", 64'(alu_out), 64'h0005);
    check("pass_z", 64'(flag_z), 64'd0);
    check("pass_c", 64'(flag_c), 64'd0);

    op1(0, 0, 1, 1, 1, 1, lat, bc);
    check("sub_wrap", 64'(alu_out), 64'hFFFF);
    op1(1, 0, 1, 0, 0, 7, lat, bc);
    check("pass_reg", 64'(alu_out), 64'hFFFF);
    op1(1, 0, 1, 1, 1, 0, lat, bc);
    check("add_res", 64'(alu_out), 64'h0000);
    check("add_z", 64'(flag_z), 64'd1);
    check("add_c", 64'(flag_c), 64'd1);

    pc_op(2, 'h10);
    pc_op(3, 'hFE);
    check("branch_taken", 64'(pc_out), 64'h000E);

    op1(1, 0, 1, 1, 1, 1, lat, bc);
    check("sub_res", 64'(alu_out), 64'hFFFF);
    check("sub_c", 64'(flag_c), 64'd1);
    check("sub_z", 64'(flag_z), 64'd0);
    pc_op(2, 'h10);
    pc_op(3, 'hFE);
    check("branch_not_taken", 64'(pc_out), 64'h0011);

    op1(2, 0, 1, 1, 0, 7, lat, bc);
    pc_op(2, 0);
    pc_op(3, 'hFF);
    check("pc_neg", 64'(pc_out), 64'hFFFF);
    pc_op(1, 0);
    check("pc_wrap", 64'(pc_out), 64'h0000);

    // en_in held while busy: only the first launch may run
    set_op(3, 0, 1, 1, 1, 0);
    en_in = 1;
    tick();
    rd = 2'd2;
    tick();
    tick();
    en_in = 0;
    cnt = 0;
    repeat (8) begin tick(); if (en_out === 1'b1) cnt++; end
    check("single_en_out", 64'(cnt), 64'd1);
    op1(0, 3, 0, 0, 0, 7, lat, bc);
    check("busy_ignored_r3", 64'(alu_out), 64'h0001);
    op1(0, 2, 0, 0, 0, 7, lat, bc);
    check("busy_ignored_r2", 64'(alu_out), 64'h0000);

    // back-to-back: second launch lands in the first one's en_out cycle
    op1(3, 0, 1, 1, 'h33, 7, lat, bc);
    op1(0, 3, 0, 0, 0, 7, lat, bc);
    check("raw_value", 64'(alu_out), 64'h0033);
    check("raw_latency", 64'(lat), 64'd3);

    // reset while the op sits in EXEC
    set_op(2, 0, 1, 1, 7, 0);
    en_in = 1;
    tick();
    en_in = 0;
    tick();
    check("in_exec_busy", 64'(busy), 64'd1);
    rst = 1;
    tick();
    rst = 0;
    check("abort_busy", 64'(busy), 64'd0);
    cnt = 0;
    repeat (4) begin tick(); if (en_out === 1'b1) cnt++; end
    check("abort_no_en_out", 64'(cnt), 64'd0);
    op1(0, 2, 0, 0, 0, 7, lat, bc);
    check("abort_r2", 64'(alu_out), 64'h0000);

    op2(7, 0, 1, 1, 1, 1);
    check("w32_sub", 64'(alu_out2), 64'hFFFF_FFFF);
    op2(7, 0, 1, 1, 1, 0);
    check("w32_add", 64'(alu_out2), 64'h0);
    check("w32_z", 64'(flag_z2), 64'd1);
    check("w32_c", 64'(flag_c2), 64'd1);
    op2(0, 7, 0, 0, 0, 7);
    check("w32_r7", 64'(alu_out2), 64'h0);
    check("w32_pc", 64'(pc_out2), 64'h0);
    check("w32_idle", 64'(busy2), 64'd0);

    repeat (1500) begin
      en_in       = ($urandom % 3 == 0);
      rd          = RAW'($urandom);
      rs          = RAW'($urandom);
      reg_wr      = ($urandom % 4 != 0);
      alu_in_sel  = $urandom % 2 == 1;
      offset      = ($urandom % 4 == 0) ? 8'hFF : OFFW'($urandom);
      alu_func    = 3'($urandom);
      en_pc_pulse = ($urandom % 2 == 1);
      pc_ctrl     = 2'($urandom);
      offset_addr = OFFW'($urandom);
      rst         = ($urandom % 200 == 0);
      tick();
    end
    rst = 0; en_in = 0; en_pc_pulse = 0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
